// File: rtl/iq_demod_decim_pkg.sv
// Shared DSP definitions for the I/Q capture path: sample width, NCO
// defaults and quadrant encoding, plus the signed 8-bit saturation helper.
package iq_demod_decim_pkg;

  localparam int IQ_W          = 8;
  localparam int DEF_PHW       = 16;
  localparam int DEF_PHASE_INC = 4096;

  // Quadrant of the NCO phase, taken from its two MSBs.
  typedef enum logic [1:0] {
    QD_0 = 2'd0,
    QD_1 = 2'd1,
    QD_2 = 2'd2,
    QD_3 = 2'd3
  } quad_e;

  // Clamp a signed value into the signed 8-bit range.
  function automatic logic signed [IQ_W-1:0] sat_s8(input logic signed [31:0] v);
    logic signed [IQ_W-1:0] r;
    if (v > 32'sd127) begin
      r = 8'h7F;
    end else if (v < -32'sd128) begin
      r = 8'h80;
    end else begin
      r = v[IQ_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_demod_decim_if.sv
// Result bus from the demodulator to the capture stage. No backpressure:
// the consumer samples on rdy. The power field exists only with IQ_POWER_EN.
interface iq_demod_decim_if;
  import iq_demod_decim_pkg::*;

  logic                   rdy;
  logic signed [IQ_W-1:0] i_value_reg;
  logic signed [IQ_W-1:0] q_value_reg;
`ifdef IQ_POWER_EN
  logic [15:0]            power;
`endif

  modport master (
    output rdy,
    output i_value_reg,
`ifdef IQ_POWER_EN
    output power,
`endif
    output q_value_reg
  );

  modport slave (
    input rdy,
    input i_value_reg,
`ifdef IQ_POWER_EN
    input power,
`endif
    input q_value_reg
  );

endinterface

// File: rtl/iq_demod_decim_quad_nco.sv
// Quadrature square-wave NCO. The LO signs are registered from the next
// phase so they always describe the phase currently held in phase_q.
// lo_*_pos = 1 means +1, 0 means -1.
module quad_nco
  import iq_demod_decim_pkg::*;
#(
  parameter int PHW       = DEF_PHW,
  parameter int PHASE_INC = DEF_PHASE_INC
) (
  input  logic clk,
  input  logic rst,
  output logic lo_i_pos,
  output logic lo_q_pos
);

  logic [PHW-1:0] phase_q, phase_d;
  logic           lo_i_pos_q, lo_i_pos_d;
  logic           lo_q_pos_q, lo_q_pos_d;
  quad_e          qd_s;

  // Next phase and the LO signs that belong to it.
  always_comb begin
    phase_d    = phase_q + PHW'(PHASE_INC);
    qd_s       = quad_e'(phase_d[PHW-1:PHW-2]);
    lo_i_pos_d = 1'b1;
    lo_q_pos_d = 1'b1;
    case (qd_s)
      QD_0: begin lo_i_pos_d = 1'b1; lo_q_pos_d = 1'b1; end
      QD_1: begin lo_i_pos_d = 1'b0; lo_q_pos_d = 1'b1; end
      QD_2: begin lo_i_pos_d = 1'b0; lo_q_pos_d = 1'b0; end
      QD_3: begin lo_i_pos_d = 1'b1; lo_q_pos_d = 1'b0; end
      default: begin lo_i_pos_d = 1'b1; lo_q_pos_d = 1'b1; end
    endcase
  end

  // Phase accumulator and LO sign registers; reset phase 0 is quadrant 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      lo_i_pos_q <= 1'b1;
      lo_q_pos_q <= 1'b1;
    end else begin
      phase_q    <= phase_d;
      lo_i_pos_q <= lo_i_pos_d;
      lo_q_pos_q <= lo_q_pos_d;
    end
  end

  assign lo_i_pos = lo_i_pos_q;
  assign lo_q_pos = lo_q_pos_q;

endmodule

// File: rtl/iq_demod_decim.sv
// 1-bit I/Q demodulator with integrate-and-dump decimation by 2^DEC_LOG2.
// Optional macro IQ_POWER_EN adds a registered I^2+Q^2 output and delays
// rdy/I/Q by one cycle so every output lines up with power.
module iq_demod_decim
  import iq_demod_decim_pkg::*;
#(
  parameter int PHW       = DEF_PHW,
  parameter int PHASE_INC = DEF_PHASE_INC,
  parameter int DEC_LOG2  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  iq_demod_decim_if.master out_if
);

  localparam int ACC_W = DEC_LOG2 + 2;
  localparam int SHIFT = DEC_LOG2 - 7;

  if (DEC_LOG2 < 7) begin : g_bad_dec
    $error("iq_demod_decim: DEC_LOG2 must be >= 7");
  end

  localparam logic signed [ACC_W-1:0] P_ONE   = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] M_ONE   = {ACC_W{1'b1}};
  localparam logic [DEC_LOG2-1:0]     CNT_ONE = {{(DEC_LOG2-1){1'b0}}, 1'b1};

  logic                    sig_meta_q, sig_sync_q;
  logic                    lo_i_pos_s, lo_q_pos_s;
  logic                    p_i_pos_s, p_q_pos_s;
  logic signed [ACC_W-1:0] p_i_s, p_q_s, sum_i_s, sum_q_s, sh_i_s, sh_q_s;
  logic [DEC_LOG2-1:0]     cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic                    win_end_s;
  logic                    rdy_q, rdy_d;
  logic signed [IQ_W-1:0]  i_value_q, i_value_d, q_value_q, q_value_d;

  quad_nco #(
    .PHW       (PHW),
    .PHASE_INC (PHASE_INC)
  ) u_nco (
    .clk      (clk),
    .rst      (rst),
    .lo_i_pos (lo_i_pos_s),
    .lo_q_pos (lo_q_pos_s)
  );

  // Two-flop synchroniser for the asynchronous comparator input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_meta_q <= 1'b0;
      sig_sync_q <= 1'b0;
    end else begin
      sig_meta_q <= sig;
      sig_sync_q <= sig_meta_q;
    end
  end

  // Mix by sign agreement (XNOR), integrate, and dump at the window end.
  always_comb begin
    p_i_pos_s = ~(sig_sync_q ^ lo_i_pos_s);
    p_q_pos_s = ~(sig_sync_q ^ lo_q_pos_s);
    p_i_s     = p_i_pos_s ? P_ONE : M_ONE;
    p_q_s     = p_q_pos_s ? P_ONE : M_ONE;
    sum_i_s   = acc_i_q + p_i_s;
    sum_q_s   = acc_q_q + p_q_s;
    sh_i_s    = sum_i_s >>> SHIFT;
    sh_q_s    = sum_q_s >>> SHIFT;
    win_end_s = &cnt_q;
    cnt_d     = cnt_q + CNT_ONE;
    acc_i_d   = sum_i_s;
    acc_q_d   = sum_q_s;
    i_value_d = i_value_q;
    q_value_d = q_value_q;
    rdy_d     = 1'b0;
    if (win_end_s) begin
      acc_i_d   = '0;
      acc_q_d   = '0;
      i_value_d = sat_s8(32'(sh_i_s));
      q_value_d = sat_s8(32'(sh_q_s));
      rdy_d     = 1'b1;
    end else begin
      acc_i_d   = sum_i_s;
      acc_q_d   = sum_q_s;
      rdy_d     = 1'b0;
    end
  end

  // Sample counter, accumulators and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_i_q   <= '0;
      acc_q_q   <= '0;
      i_value_q <= '0;
      q_value_q <= '0;
      rdy_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_i_q   <= acc_i_d;
      acc_q_q   <= acc_q_d;
      i_value_q <= i_value_d;
      q_value_q <= q_value_d;
      rdy_q     <= rdy_d;
    end
  end

`ifdef IQ_POWER_EN
  logic signed [15:0]     i_ext_s, q_ext_s;
  logic [15:0]            power_q, power_d;
  logic                   rdy_p_q;
  logic signed [IQ_W-1:0] i_p_q, q_p_q;

  // Squared magnitude of the registered results; 32768 maps to 16'h8000.
  always_comb begin
    i_ext_s = 16'(i_value_q);
    q_ext_s = 16'(q_value_q);
    power_d = 16'(i_ext_s * i_ext_s + q_ext_s * q_ext_s);
  end

  // Multiplier pipeline stage; rdy/I/Q ride along to stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      power_q <= '0;
      rdy_p_q <= 1'b0;
      i_p_q   <= '0;
      q_p_q   <= '0;
    end else begin
      power_q <= power_d;
      rdy_p_q <= rdy_q;
      i_p_q   <= i_value_q;
      q_p_q   <= q_value_q;
    end
  end

  assign out_if.rdy         = rdy_p_q;
  assign out_if.i_value_reg = i_p_q;
  assign out_if.q_value_reg = q_p_q;
  assign out_if.power       = power_q;
`else
  assign out_if.rdy         = rdy_q;
  assign out_if.i_value_reg = i_value_q;
  assign out_if.q_value_reg = q_value_q;
`endif

endmodule

// File: tb/tb_iq_demod_decim.sv
// Bench for iq_demod_decim with default parameters. Reference model sums
// sign(sig_s)*LO over each window from the driven history, then divides.
module tb_iq_demod_decim;

  localparam int PHW       = 16;
  localparam int PHASE_INC = 4096;
  localparam int WIN       = 1024;
`ifdef IQ_POWER_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;
  logic sig;

  iq_demod_decim_if dut_if ();

  iq_demod_decim dut (
    .clk    (clk),
    .rst    (rst),
    .sig    (sig),
    .out_if (dut_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit hist [0:8191];
  int rdy_cyc_q [$];
  int rdy_i_q   [$];
  int rdy_q_q   [$];
  int rdy_p_q   [$];

  function automatic int lo_i_at(int k);
    int qd;
    qd = (((k - 1) * PHASE_INC) % (1 << PHW)) / (1 << (PHW - 2));
    return (qd == 0 || qd == 3) ? 1 : -1;
  endfunction

  function automatic int lo_q_at(int k);
    int qd;
    qd = (((k - 1) * PHASE_INC) % (1 << PHW)) / (1 << (PHW - 2));
    return (qd == 0 || qd == 1) ? 1 : -1;
  endfunction

  function automatic int floor_div8(int x);
    return (x >= 0) ? x / 8 : -((-x + 7) / 8);
  endfunction

  // Expected I/Q/power for window w (1-based) since the last reset.
  task automatic model_window(input int w, output int ei, output int eq, output int ep);
    int si, sq, s;
    si = 0;
    sq = 0;
    for (int k = (w - 1) * WIN + 1; k <= w * WIN; k++) begin
      s = (k <= 2) ? -1 : (hist[k - 2] ? 1 : -1);
      si += s * lo_i_at(k);
      sq += s * lo_q_at(k);
    end
    ei = floor_div8(si);
    eq = floor_div8(sq);
    if (ei > 127) ei = 127;
    if (eq > 127) eq = 127;
    ep = ei * ei + eq * eq;
  endtask

  // 0: const 1, 1: in-phase, 2: inverted in-phase, 3: quadrature, 4: random
  function automatic logic sig_for(int mode, int k);
    logic r;
    case (mode)
      0: r = 1'b1;
      1: r = (lo_i_at(k + 2) == 1);
      2: r = (lo_i_at(k + 2) != 1);
      3: r = (lo_q_at(k + 2) == 1);
      default: r = 1'($urandom_range(0, 1));
    endcase
    return r;
  endfunction

  task automatic clear_obs();
    rdy_cyc_q.delete();
    rdy_i_q.delete();
    rdy_q_q.delete();
    rdy_p_q.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    sig = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    clear_obs();
  endtask

  // Drive sig for one cycle and record any rdy strobe of the following cycle.
  task automatic tick(input logic s);
    cyc = cyc + 1;
    hist[cyc] = s;
    sig = s;
    @(posedge clk);
    #1;
    if (dut_if.rdy === 1'b1) begin
      rdy_cyc_q.push_back(cyc + 1);
      rdy_i_q.push_back(int'(dut_if.i_value_reg));
      rdy_q_q.push_back(int'(dut_if.q_value_reg));
`ifdef IQ_POWER_EN
      rdy_p_q.push_back(int'(dut_if.power));
`else
      rdy_p_q.push_back(0);
`endif
    end
  endtask

  task automatic run(input int mode, input int n);
    for (int j = 0; j < n; j++) tick(sig_for(mode, cyc + 1));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      sig = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    #1;
    n_total++;
    if (dut_if.rdy !== 1'b0 || dut_if.i_value_reg !== 8'sd0 || dut_if.q_value_reg !== 8'sd0) begin
      $display("FAIL reset_vals: rdy=%b i=%0d q=%0d, expected 0/0/0", dut_if.rdy,
               dut_if.i_value_reg, dut_if.q_value_reg);
    end else n_pass++;
`ifdef IQ_POWER_EN
    n_total++;
    if (dut_if.power !== 16'd0) $display("FAIL reset_power: got %0d expected 0", dut_if.power);
    else n_pass++;
`endif
    rst = 1'b0;
    cyc = 0;
    clear_obs();
  endtask

  task automatic test_cadence();
    int ei, eq, ep;
    do_reset(2);
    run(0, 3 * WIN + LAT + 4);
    n_total++;
    if (rdy_cyc_q.size() !== 3) $display("FAIL cadence_count: got %0d strobes expected 3", rdy_cyc_q.size());
    else n_pass++;
    for (int w = 1; w <= 3; w++) begin
      if (rdy_cyc_q.size() >= w) begin
        model_window(w, ei, eq, ep);
        n_total++;
        if (rdy_cyc_q[w-1] !== w * WIN + LAT)
          $display("FAIL cadence_pos w%0d: got cycle %0d expected %0d", w, rdy_cyc_q[w-1], w * WIN + LAT);
        else n_pass++;
        n_total++;
        if (rdy_i_q[w-1] !== ei || rdy_q_q[w-1] !== eq)
          $display("FAIL cadence_iq w%0d: got %0d/%0d expected %0d/%0d", w, rdy_i_q[w-1], rdy_q_q[w-1], ei, eq);
        else n_pass++;
      end
    end
    n_total++;
    if (rdy_cyc_q.size() == 3 && (rdy_i_q[2] !== 0 || rdy_q_q[2] !== 0))
      $display("FAIL cadence_cancel: got %0d/%0d expected 0/0", rdy_i_q[2], rdy_q_q[2]);
    else n_pass++;
  endtask

  task automatic test_drive(input string name, input int mode, input int want_i, input int want_q);
    int ei, eq, ep;
    do_reset(2);
    run(mode, 2 * WIN + LAT + 2);
    n_total++;
    if (rdy_cyc_q.size() !== 2) $display("FAIL %s_count: got %0d strobes expected 2", name, rdy_cyc_q.size());
    else n_pass++;
    if (rdy_cyc_q.size() == 2) begin
      model_window(1, ei, eq, ep);
      n_total++;
      if (rdy_i_q[0] !== ei || rdy_q_q[0] !== eq)
        $display("FAIL %s_w1: got %0d/%0d expected %0d/%0d", name, rdy_i_q[0], rdy_q_q[0], ei, eq);
      else n_pass++;
      n_total++;
      if (rdy_i_q[1] !== want_i || rdy_q_q[1] !== want_q)
        $display("FAIL %s_w2: got %0d/%0d expected %0d/%0d", name, rdy_i_q[1], rdy_q_q[1], want_i, want_q);
      else n_pass++;
`ifdef IQ_POWER_EN
      n_total++;
      if (rdy_p_q[1] !== want_i * want_i + want_q * want_q)
        $display("FAIL %s_power: got %0d expected %0d", name, rdy_p_q[1], want_i * want_i + want_q * want_q);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_random();
    int ei, eq, ep;
    do_reset(2);
    run(4, 3 * WIN + LAT + 2);
    n_total++;
    if (rdy_cyc_q.size() !== 3) $display("FAIL random_count: got %0d strobes expected 3", rdy_cyc_q.size());
    else n_pass++;
    for (int w = 1; w <= 3; w++) begin
      if (rdy_cyc_q.size() >= w) begin
        model_window(w, ei, eq, ep);
        n_total++;
        if (rdy_i_q[w-1] !== ei || rdy_q_q[w-1] !== eq || rdy_cyc_q[w-1] !== w * WIN + LAT)
          $display("FAIL random_w%0d: got %0d/%0d@%0d expected %0d/%0d@%0d", w, rdy_i_q[w-1],
                   rdy_q_q[w-1], rdy_cyc_q[w-1], ei, eq, w * WIN + LAT);
        else n_pass++;
`ifdef IQ_POWER_EN
        n_total++;
        if (rdy_p_q[w-1] !== ep) $display("FAIL random_power w%0d: got %0d expected %0d", w, rdy_p_q[w-1], ep);
        else n_pass++;
`endif
      end
    end
  endtask

  task automatic test_reset_mid_window();
    int bad;
    do_reset(2);
    run(1, WIN + 500);
    n_total++;
    if (dut_if.i_value_reg !== 8'sd127) $display("FAIL midrst_pre: got I=%0d expected 127", dut_if.i_value_reg);
    else n_pass++;
    do_reset(1);
    n_total++;
    if (dut_if.rdy !== 1'b0 || dut_if.i_value_reg !== 8'sd0 || dut_if.q_value_reg !== 8'sd0)
      $display("FAIL midrst_clear: rdy=%b i=%0d q=%0d expected 0/0/0", dut_if.rdy,
               dut_if.i_value_reg, dut_if.q_value_reg);
    else n_pass++;
    bad = 0;
    for (int j = 0; j < WIN + LAT + 2; j++) begin
      tick(sig_for(1, cyc + 1));
      if (cyc + 1 < WIN + LAT &&
          (dut_if.rdy !== 1'b0 || dut_if.i_value_reg !== 8'sd0 || dut_if.q_value_reg !== 8'sd0))
        bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL midrst_quiet: got %0d non-idle cycles expected 0", bad);
    else n_pass++;
    n_total++;
    if (rdy_cyc_q.size() !== 1 || rdy_cyc_q[0] !== WIN + LAT)
      $display("FAIL midrst_first: got %0d strobes first@%0d expected 1@%0d", rdy_cyc_q.size(),
               (rdy_cyc_q.size() > 0) ? rdy_cyc_q[0] : -1, WIN + LAT);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    sig = 1'b0;
    test_reset();
    test_cadence();
    test_drive("inphase", 1, 127, 0);
    test_drive("inverted", 2, -128, 0);
    test_drive("quad", 3, 0, 127);
    test_random();
    test_reset_mid_window();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
